// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler
// Shares one N-bit signed ALU (Add/Sub/Mult) between two requesters.
// Requesters are arbitrated round-robin. The accepted command's operands are
// held on the ALU for the operation's latency. The result is sign-extended to
// 2N bits and returned with the requester id on the response channel.
//
// Handshake rule for every channel in this block: a transfer happens in the
// cycle where valid and ready are both 1 at the rising clock edge. The
// producer holds valid and payload stable until that transfer. Ready is only
// raised in IDLE and is combinational from valid, so a requester that drops
// valid is simply not granted.
module alu_req_scheduler #(
   parameter int N          = 4,
   parameter int ADDSUB_LAT = 1,
   parameter int MULT_LAT   = 3
) (
   input  logic             clk,
   input  logic             rst,
   // requester 0
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [N-1:0]     req0_a,
   input  logic [N-1:0]     req0_b,
   // requester 1
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [N-1:0]     req1_a,
   input  logic [N-1:0]     req1_b,
   // ALU side
   output logic [N-1:0]     alu_a,
   output logic [N-1:0]     alu_b,
   output logic [1:0]       alu_op,
   input  logic [2*N-1:0]   alu_result,
   // response channel
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [2*N-1:0]   rsp_data,
   output logic             rsp_err,
   // status
   output logic             busy,
   output logic [1:0]       state_dbg
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam int MAX_LAT = (ADDSUB_LAT > MULT_LAT) ? ADDSUB_LAT : MULT_LAT;
   localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [CW-1:0] ADDSUB_CNT = CW'(ADDSUB_LAT - 1);
   localparam logic [CW-1:0] MULT_CNT   = CW'(MULT_LAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            last_grant;
   logic [CW-1:0]   cnt;

   // arbitration results
   logic            grant_id;
   logic            sel_valid;
   logic [1:0]      sel_op;
   logic [N-1:0]    sel_a;
   logic [N-1:0]    sel_b;
   logic            accept;

   assign state_dbg = state;
   assign busy      = (state != IDLE);

   // Round-robin pick: on contention the requester not granted last time wins;
   // a lone valid requester always wins. Re-evaluated every cycle, no locking.
   always_comb begin
      grant_id = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant;
      end else if (req1_valid) begin
         grant_id = 1'b1;
      end
   end

   // Payload of the currently granted requester.
   always_comb begin
      sel_valid = req0_valid;
      sel_op    = req0_op;
      sel_a     = req0_a;
      sel_b     = req0_b;
      if (grant_id) begin
         sel_valid = req1_valid;
         sel_op    = req1_op;
         sel_a     = req1_a;
         sel_b     = req1_b;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, handshake outputs. Ready is held low while rst is asserted
   // so nothing is accepted in the reset cycle itself.
   always_comb begin
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      rsp_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (!rst && sel_valid) begin
               accept     = 1'b1;
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_next = (sel_op == OP_ILL) ? RESP : EXEC;
            end
         end
         EXEC: begin
            if (cnt == '0) begin
               state_next = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: latch the accepted command, count down the ALU latency and
   // capture the result. The ALU operand registers only change on a legal
   // accept, so the displayed result stays stable across IDLE, RESP and
   // illegal commands.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= OP_ADD;
         cnt        <= '0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else if (accept) begin
         last_grant <= grant_id;
         rsp_id     <= grant_id;
         if (sel_op == OP_ILL) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
         end else begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            cnt    <= (sel_op == OP_MUL) ? MULT_CNT : ADDSUB_CNT;
         end
      end else if (state == EXEC) begin
         if (cnt == '0) begin
            // Add/Sub results live in the low N bits; Mult uses all 2N.
            if (alu_op == OP_MUL) begin
               rsp_data <= alu_result;
            end else begin
               rsp_data <= {{N{alu_result[N-1]}}, alu_result[N-1:0]};
            end
            rsp_err <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // OP_SUB is part of the encoding but needs no special handling here.
   logic unused_sub;
   assign unused_sub = (alu_op == OP_SUB);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed testbench for alu_req_scheduler (N=4, ADDSUB_LAT=1, MULT_LAT=3).
// The bench plays the ALU: a combinational model that puts junk in the upper
// bits of Add/Sub results, so the scheduler's own sign extension is exercised.
module tb_alu_req_scheduler;

   localparam int N = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             req0_valid = 1'b0;
   logic             req0_ready;
   logic [1:0]       req0_op = 2'b00;
   logic [N-1:0]     req0_a = '0;
   logic [N-1:0]     req0_b = '0;
   logic             req1_valid = 1'b0;
   logic             req1_ready;
   logic [1:0]       req1_op = 2'b00;
   logic [N-1:0]     req1_a = '0;
   logic [N-1:0]     req1_b = '0;
   logic [N-1:0]     alu_a;
   logic [N-1:0]     alu_b;
   logic [1:0]       alu_op;
   logic [2*N-1:0]   alu_result;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic             rsp_id;
   logic [2*N-1:0]   rsp_data;
   logic             rsp_err;
   logic             busy;
   logic [1:0]       state_dbg;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   alu_req_scheduler #(.N(N), .ADDSUB_LAT(1), .MULT_LAT(3)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy), .state_dbg(state_dbg)
   );

   // ALU model
   logic signed [7:0] pa, pb;
   always_comb begin
      pa = {{4{alu_a[3]}}, alu_a};
      pb = {{4{alu_b[3]}}, alu_b};
      case (alu_op)
         2'b00:   alu_result = {4'b0101, alu_a + alu_b};
         2'b01:   alu_result = {4'b0101, alu_a - alu_b};
         2'b10:   alu_result = pa * pb;
         default: alu_result = 8'h00;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      if (id == 1'b0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   // One command from IDLE with rsp_ready=1; called at a falling edge.
   task automatic do_cmd(input logic id, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input int lat, input logic exp_err,
                         input logic [3:0] ea, input logic [3:0] eb, input logic [1:0] eop);
      logic [7:0] exp_data;
      exp_data = exp_q.pop_front();
      drive_req(id, op, a, b);
      #1;
      chk("accept_ready", id ? req1_ready : req0_ready, 1);
      chk("other_ready", id ? req0_ready : req1_ready, 0);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int i = 0; i < lat; i++) begin
         chk("exec_busy", busy, 1);
         chk("exec_no_rsp", rsp_valid, 0);
         chk("exec_alu_a", alu_a, ea);
         chk("exec_alu_op", alu_op, eop);
         @(negedge clk);
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, id);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_err", rsp_err, exp_err);
      chk("rsp_alu_a", alu_a, ea);
      chk("rsp_alu_b", alu_b, eb);
      chk("rsp_alu_op", alu_op, eop);
      @(negedge clk);
      chk("back_idle", busy, 0);
   endtask

   initial begin
      int ngrants;
      int g;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_state", state_dbg, 0);
      rst = 1'b0;
      @(negedge clk);

      // basic ops: 3+2, (-8)*(-8), -8-1 wraps to 7, 7+1 wraps to -8
      exp_q.push_back(8'h05);
      exp_q.push_back(8'h40);
      exp_q.push_back(8'h07);
      exp_q.push_back(8'hF8);
      exp_q.push_back(8'h00);
      do_cmd(1'b0, 2'b00, 4'd3, 4'd2, 1, 1'b0, 4'd3, 4'd2, 2'b00);
      do_cmd(1'b1, 2'b10, 4'b1000, 4'b1000, 3, 1'b0, 4'b1000, 4'b1000, 2'b10);
      do_cmd(1'b1, 2'b01, 4'b1000, 4'd1, 1, 1'b0, 4'b1000, 4'd1, 2'b01);
      do_cmd(1'b0, 2'b00, 4'd7, 4'd1, 1, 1'b0, 4'd7, 4'd1, 2'b00);
      // illegal opcode: immediate error response, ALU keeps 7+1
      do_cmd(1'b0, 2'b11, 4'd5, 4'd5, 0, 1'b1, 4'd7, 4'd1, 2'b00);

      // response stall for 10 cycles with a request pending
      rsp_ready = 1'b0;
      drive_req(1'b0, 2'b00, 4'd1, 4'd1);
      #1 chk("stall_accept", req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      drive_req(1'b1, 2'b01, 4'd5, 4'd3);
      #1 chk("stall_exec_ready", req1_ready, 0);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         chk("stall_rsp_valid", rsp_valid, 1);
         chk("stall_rsp_data", rsp_data, 8'h02);
         chk("stall_rsp_id", rsp_id, 0);
         chk("stall_ready", req1_ready, 0);
         chk("stall_busy", busy, 1);
         chk("stall_alu_a", alu_a, 1);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1 chk("hs_cycle_ready", req1_ready, 0);
      @(negedge clk);
      chk("post_stall_idle", busy, 0);
      chk("post_stall_grant", req1_ready, 1);
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      chk("pend_rsp_valid", rsp_valid, 1);
      chk("pend_rsp_id", rsp_id, 1);
      chk("pend_rsp_data", rsp_data, 8'h02);
      @(negedge clk);

      // reset in the middle of a multiply
      drive_req(1'b0, 2'b10, 4'd2, 4'd3);
      #1 chk("mul_accept", req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      chk("mul_exec", state_dbg, 1);
      rst = 1'b1;
      drive_req(1'b0, 2'b00, 4'd1, 4'd1);
      drive_req(1'b1, 2'b00, 4'd2, 4'd2);
      #1;
      chk("rst_cyc_ready0", req0_ready, 0);
      chk("rst_cyc_ready1", req1_ready, 0);
      @(negedge clk);
      chk("mrst_busy", busy, 0);
      chk("mrst_rsp_valid", rsp_valid, 0);
      chk("mrst_alu_a", alu_a, 0);
      chk("mrst_alu_b", alu_b, 0);
      chk("mrst_alu_op", alu_op, 0);
      chk("mrst_rsp_data", rsp_data, 0);
      chk("mrst_rsp_err", rsp_err, 0);
      chk("mrst_state", state_dbg, 0);
      rst = 1'b0;
      #1;
      chk("first_grant_req0", req0_ready, 1);
      chk("first_grant_not_req1", req1_ready, 0);

      // both requesters valid continuously: grants alternate 0,1,0,1
      exp_q.delete();
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd1);
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd1);
      ngrants = 0;
      for (int cyc = 0; cyc < 40 && ngrants < 4; cyc++) begin
         g = -1;
         if (req0_ready) g = 0;
         if (req1_ready) g = 1;
         if (req0_ready && req1_ready) chk("dual_ready", 1, 0);
         if (g >= 0) begin
            chk("grant_order", g, {24'd0, exp_q.pop_front()});
            ngrants++;
         end
         if (rsp_valid) chk("alt_rsp_data", rsp_data, rsp_id ? 8'h04 : 8'h02);
         @(negedge clk);
         #1;
      end
      chk("grant_count", ngrants, 4);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int cyc = 0; cyc < 10 && busy; cyc++) begin
         if (rsp_valid) chk("tail_rsp_data", rsp_data, rsp_id ? 8'h04 : 8'h02);
         @(negedge clk);
         #1;
      end
      chk("final_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_req_scheduler.md
# alu_req_scheduler

Shares the single N-bit signed ALU (Add/Sub/Mult) between two requesters, such as the switch/key panel and a second command source. It does this with round-robin arbitration and valid/ready handshakes. The block latches each accepted command's operands and opcode, and drives them onto the ALU for the operation's fixed latency. It then captures the result, sign-extended to 2N bits, and returns it with the requester ID on a response channel. It sits between the requester front-ends and the ALU instance in the top level.

## Interface
- N, 4, operand width (signed two's complement)
- ADDSUB_LAT, 1, cycles ALU needs for a stable Add/Sub result (≥1)
- MULT_LAT, 3, cycles ALU needs for a stable Mult result (≥1)

- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  command present from requester 0 / 1
- req0_ready / req1_ready  out  1  command accepted this cycle when valid&ready
- req0_op / req1_op  in  2  00=Add, 01=Sub, 10=Mult, 11=illegal
- req0_a, req0_b / req1_a, req1_b  in  N  signed operands
- alu_a, alu_b  out  N  operands to ALU
- alu_op  out  2  opcode to ALU (same encoding)
- alu_result  in  2N  ALU output; Add/Sub valid in low N bits, Mult full 2N
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the command
- rsp_data  out  2N  signed result
- rsp_err  out  1  command had illegal opcode
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - last_grant register; reset value 1, so req0 wins first.
  - If both requesters are valid, grant the one ≠ last_grant; if only one is valid, grant it.
  - req_ready[g] = (state==IDLE) && granted && valid; the non-granted ready is 0.
  - Arbitration is re-evaluated every IDLE cycle, with no lock on an un-accepted request.
- Accept (valid&ready): latch op, a, b and id; set last_grant=id.
  - op ∈ {00,01}: cnt←ADDSUB_LAT−1, go to EXEC.
  - op=10: cnt←MULT_LAT−1, go to EXEC.
  - op=11: rsp_data←0, rsp_err←1, go to RESP; ALU outputs unchanged.
- EXEC: alu_a/alu_b/alu_op are driven from the latched registers. Decrement cnt. When cnt==0:
  - capture rsp_data: Add/Sub = sign-extend alu_result[N−1:0] to 2N; Mult = alu_result[2N−1:0]
  - rsp_err←0; go to RESP.
- RESP: rsp_valid=1; rsp_id/rsp_data/rsp_err held stable until rsp_ready. On valid&ready go to IDLE.
- ALU outputs keep the last command's values in IDLE and RESP, so the displayed result stays stable.
- Arithmetic wrap is the ALU's (N-bit for Add/Sub); the scheduler does no saturation or flagging.
- Requesters must hold valid and payload stable until ready. A dropped valid is simply not granted.
- Reset values: state=IDLE; req0_ready=req1_ready=0; alu_a=alu_b=0; alu_op=00; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_err=0; busy=0; last_grant=1.

## Timing
- Accept in cycle T. EXEC occupies T+1 … T+LAT, and the result is captured at the end of T+LAT. rsp_valid is high from T+LAT+1.
  - Add/Sub (LAT=1): rsp_valid at T+2.
  - Mult (LAT=3): rsp_valid at T+4.
  - Illegal: rsp_valid at T+1.
- Response handshake in cycle R → IDLE at R+1; next accept earliest R+1.
  - Back-to-back Add throughput: 1 command per 3 cycles.
- rsp_ready held low stalls indefinitely. Both req_ready stay 0, and the ALU inputs hold.
- rst asserted in any state (EXEC/RESP mid-operation): next cycle all outputs take reset values. The in-flight command is dropped with no response; last_grant returns to 1.
- Requests asserted in the same cycle as the response handshake are not accepted until IDLE (R+1).

## Test plan
- Reset, then req0 Add a=3,b=2 accepted at T → alu_op=00, alu_a=3, alu_b=2 from T+1; rsp_valid at T+2, rsp_data=0x05, rsp_id=0, rsp_err=0.
- req1 Mult a=−8 (4'b1000), b=−8 → rsp_valid 4 cycles after accept, rsp_data=0x40, rsp_id=1; Sub a=−8,b=1 → wraps to 7, rsp_data=0x07; Add 7+1 → rsp_data=0xF8.
- Both valid continuously after reset, rsp_ready=1 → grants alternate 0,1,0,1; req0 is first; neither requester starves.
- req0_op=11 → rsp_valid at T+1, rsp_err=1, rsp_data=0; ALU outputs unchanged from the previous command.
- rsp_ready low 10 cycles during RESP → rsp fields stable, req_ready=0, busy=1; raise rsp_ready → IDLE next cycle, then the pending request is accepted.
- rst pulsed during Mult EXEC → next cycle state IDLE, all outputs at reset values, no rsp_valid; first grant afterwards goes to req0.
